// File: rtl/led_matrix_pkg.sv
// led_matrix_pkg: shared types, sizes and the comm-word helper for the 8x8 RGB matrix scanner.
package led_matrix_pkg;
  localparam int ROWS = 8;
  localparam int COLS = 8;
  typedef logic [2:0] row_t;
  typedef struct packed {
    logic r;
    logic g;
    logic b;
  } rgb_t;
  typedef struct packed {
    logic [COLS-1:0] r;
    logic [COLS-1:0] g;
    logic [COLS-1:0] b;
  } line_t;
  typedef enum logic {SCAN, SWAP_PEND} scan_state_t;
  function automatic logic [3:0] comm_word(input row_t row);
    return {1'b1, row};
  endfunction
endpackage

// File: rtl/led_scan_tick.sv
// led_scan_tick: row prescaler; div counts 0..SCAN_DIV-1 and tick marks the last cycle of a row.
module led_scan_tick #(
  parameter int SCAN_DIV = 10002,
  parameter int DW = $clog2(SCAN_DIV)
) (
  input  logic          clk,
  input  logic          clear_n,
  output logic [DW-1:0] div,
  output logic          tick
);
  logic [DW-1:0] div_q, div_d;
  always_comb begin
    tick  = div_q == DW'(SCAN_DIV - 1);
    div_d = tick ? '0 : div_q + 1'b1;
  end
  always_ff @(posedge clk or negedge clear_n)
    if (!clear_n) div_q <= '0;
    else div_q <= div_d;
  assign div = div_q;
endmodule

// File: rtl/led_matrix_scan.sv
// led_matrix_scan: double-buffered 8x8 RGB frame store with tear-free swap and active-low row scan.
// Define LED_SCAN_BLANK_EN to blank column data for BLANK_CYC cycles after each row change.
module led_matrix_scan
  import led_matrix_pkg::*;
#(
  parameter int SCAN_DIV  = 10002,
  parameter int BLANK_CYC = 64
) (
  input  logic       clk,
  input  logic       clear_n,
  input  logic       wr_en,
  input  logic [2:0] wr_row,
  input  logic [2:0] wr_col,
  input  logic [2:0] wr_rgb,
  input  logic       clear_buf,
  input  logic       swap_req,
  output logic       swap_ack,
  output logic       frame_start,
  output logic [3:0] comm,
  output logic [7:0] data_r,
  output logic [7:0] data_g,
  output logic [7:0] data_b
);
  localparam int DW = $clog2(SCAN_DIV);
`ifdef LED_SCAN_BLANK_EN
  localparam logic [DW-1:0] LOAD_AT = DW'(BLANK_CYC - 1);
`else
  localparam logic [DW-1:0] LOAD_AT = DW'(SCAN_DIV - 1);
`endif
  if (SCAN_DIV < 4 || BLANK_CYC < 1 || BLANK_CYC >= SCAN_DIV) begin : g_bad_cfg
    $error("led_matrix_scan: need SCAN_DIV >= 4 and 1 <= BLANK_CYC < SCAN_DIV");
  end
  scan_state_t           state_q, state_d;
  line_t [1:0][ROWS-1:0] fb_q, fb_d;
  line_t                 data_q, data_d;
  row_t                  row_q, row_d;
  logic [3:0]            comm_q, comm_d;
  logic                  bank_q, bank_d;
  logic                  swap_ack_q, swap_ack_d;
  logic                  frame_start_q, frame_start_d;
  logic [DW-1:0]         div;
  logic                  tick, wrap, swap_do;
  rgb_t                  px;
  assign px = rgb_t'(wr_rgb);
  led_scan_tick #(.SCAN_DIV(SCAN_DIV), .DW(DW)) u_tick (
    .clk    (clk),
    .clear_n(clear_n),
    .div    (div),
    .tick   (tick)
  );
  // A swap needs the request already pending, so a withdrawn request never flips the banks.
  always_comb begin
    wrap          = tick && row_q == row_t'(ROWS - 1);
    swap_do       = wrap && swap_req && state_q == SWAP_PEND;
    state_d       = (swap_req && !swap_do) ? SWAP_PEND : SCAN;
    row_d         = tick ? row_q + 1'b1 : row_q;
    bank_d        = swap_do ? ~bank_q : bank_q;
    comm_d        = tick ? comm_word(row_d) : comm_q;
    data_d        = tick ? '1 : data_q;
    if (div == LOAD_AT) data_d = ~fb_q[bank_d][row_d];
    swap_ack_d    = swap_do;
    frame_start_d = tick && row_d == '0;
    fb_d          = fb_q;
    if (!swap_req && clear_buf) fb_d[~bank_q] = '0;
    if (!swap_req && wr_en) begin
      fb_d[~bank_q][wr_row].r[wr_col] = px.r;
      fb_d[~bank_q][wr_row].g[wr_col] = px.g;
      fb_d[~bank_q][wr_row].b[wr_col] = px.b;
    end
  end
  always_ff @(posedge clk or negedge clear_n)
    if (!clear_n) begin
      state_q       <= SCAN;
      fb_q          <= '0;
      data_q        <= '1;
      row_q         <= '0;
      comm_q        <= comm_word('0);
      bank_q        <= 1'b0;
      swap_ack_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      fb_q          <= fb_d;
      data_q        <= data_d;
      row_q         <= row_d;
      comm_q        <= comm_d;
      bank_q        <= bank_d;
      swap_ack_q    <= swap_ack_d;
      frame_start_q <= frame_start_d;
    end
  assign swap_ack    = swap_ack_q;
  assign frame_start = frame_start_q;
  assign comm        = comm_q;
  assign data_r      = data_q.r;
  assign data_g      = data_q.g;
  assign data_b      = data_q.b;
endmodule

// File: tb/tb_led_matrix_scan.sv
// tb_led_matrix_scan: directed checks of reset, write/swap/scan, swap timing, write guard, blanking and mid-scan reset.
module tb_led_matrix_scan;
  logic       clk = 1'b0;
  logic       clear_n = 1'b0;
  logic       wr_en = 1'b0, clear_buf = 1'b0, swap_req = 1'b0;
  logic [2:0] wr_row = '0, wr_col = '0, wr_rgb = '0;
  logic       swap_ack, frame_start;
  logic [3:0] comm;
  logic [7:0] data_r, data_g, data_b;
  int         n_tests = 0, n_fail = 0;
  int         n, acks, fs, chg;
  logic [3:0] prev;
  always #5 clk = ~clk;
  led_matrix_scan #(.SCAN_DIV(16), .BLANK_CYC(4)) dut (
    .clk        (clk),
    .clear_n    (clear_n),
    .wr_en      (wr_en),
    .wr_row     (wr_row),
    .wr_col     (wr_col),
    .wr_rgb     (wr_rgb),
    .clear_buf  (clear_buf),
    .swap_req   (swap_req),
    .swap_ack   (swap_ack),
    .frame_start(frame_start),
    .comm       (comm),
    .data_r     (data_r),
    .data_g     (data_g),
    .data_b     (data_b)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic wait_comm(input logic [3:0] v);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (comm !== v && k < 200);
    if (comm !== v) check("wait_comm", {28'd0, comm}, {28'd0, v});
  endtask
  task automatic count_change(output int k, output int a);
    logic [3:0] c0;
    c0 = comm;
    k = 0;
    a = 0;
    do begin
      @(negedge clk);
      k++;
      if (swap_ack === 1'b1) a++;
    end while (comm === c0 && k < 1000);
  endtask
  task automatic wait_ack(output int rows);
    int k = 0;
    logic [3:0] p;
    p = comm;
    rows = 0;
    while (swap_ack !== 1'b1 && k < 300) begin
      @(negedge clk);
      k++;
      if (comm !== p) rows++;
      p = comm;
    end
    check("ack_seen", {31'd0, swap_ack}, 1);
  endtask
  task automatic write_px(input logic [2:0] r, input logic [2:0] c, input logic [2:0] rgb, input logic clr);
    wr_en = 1'b1;
    wr_row = r;
    wr_col = c;
    wr_rgb = rgb;
    clear_buf = clr;
    @(negedge clk);
    wr_en = 1'b0;
    clear_buf = 1'b0;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(negedge clk);
    check("rst_comm", {28'd0, comm}, 4'b1000);
    check("rst_data_r", {24'd0, data_r}, 8'hFF);
    check("rst_data_g", {24'd0, data_g}, 8'hFF);
    check("rst_data_b", {24'd0, data_b}, 8'hFF);
    check("rst_ack", {31'd0, swap_ack}, 0);
    check("rst_fs", {31'd0, frame_start}, 0);
    clear_n = 1'b1;
    count_change(n, acks);
    check("first_tick", n, 16);
    check("first_row", {28'd0, comm}, 4'b1001);
    count_change(n, acks);
    check("row_period", n, 16);
    write_px(3'd2, 3'd5, 3'b010, 1'b0);
    swap_req = 1'b1;
    wait_ack(n);
    check("ack_comm", {28'd0, comm}, 4'b1000);
    check("ack_fs", {31'd0, frame_start}, 1);
    check("row0_g", {24'd0, data_g}, 8'hFF);
    swap_req = 1'b0;
    @(negedge clk);
    check("ack_pulse", {31'd0, swap_ack}, 0);
    check("fs_pulse", {31'd0, frame_start}, 0);
    wait_comm(4'b1010);
    check("row2_g", {24'd0, data_g}, 8'b1101_1111);
    check("row2_r", {24'd0, data_r}, 8'hFF);
    check("row2_b", {24'd0, data_b}, 8'hFF);
    write_px(3'd3, 3'd0, 3'b100, 1'b0);
    wait_comm(4'b1011);
    check("pre_swap_r3", {24'd0, data_r}, 8'hFF);
    repeat (5) @(negedge clk);
    swap_req = 1'b1;
    wait_ack(chg);
    check("pend_rows", chg, 5);
    swap_req = 1'b0;
    acks = 0;
    fs = 0;
    for (int i = 0; i < 250; i++) begin
      @(negedge clk);
      if (swap_ack === 1'b1) acks++;
      if (frame_start === 1'b1) fs++;
    end
    check("single_ack", acks, 0);
    check("fs_per_frame", fs, 1);
    wait_comm(4'b1010);
    check("swapped_row2_g", {24'd0, data_g}, 8'hFF);
    wait_comm(4'b1011);
    check("swapped_row3_r", {24'd0, data_r}, 8'b1111_1110);
    write_px(3'd4, 3'd7, 3'b001, 1'b1);
    swap_req = 1'b1;
    write_px(3'd6, 3'd1, 3'b111, 1'b0);
    wait_ack(n);
    swap_req = 1'b0;
    wait_comm(4'b1100);
`ifdef LED_SCAN_BLANK_EN
    check("blank_c0", {24'd0, data_b}, 8'hFF);
    repeat (3) @(negedge clk);
    check("blank_c3", {24'd0, data_b}, 8'hFF);
    @(negedge clk);
    check("blank_load", {24'd0, data_b}, 8'h7F);
`else
    check("noblank_load", {24'd0, data_b}, 8'h7F);
`endif
    check("row4_r", {24'd0, data_r}, 8'hFF);
    check("row4_g", {24'd0, data_g}, 8'hFF);
    wait_comm(4'b1110);
    check("guard_row6_r", {24'd0, data_r}, 8'hFF);
    check("guard_row6_g", {24'd0, data_g}, 8'hFF);
    check("guard_row6_b", {24'd0, data_b}, 8'hFF);
    wait_comm(4'b1010);
    check("cleared_row2_g", {24'd0, data_g}, 8'hFF);
    swap_req = 1'b1;
    wait_comm(4'b1100);
    repeat (6) @(negedge clk);
    check("pre_reset_b", {24'd0, data_b}, 8'h7F);
    #2 clear_n = 1'b0;
    #1;
    check("async_comm", {28'd0, comm}, 4'b1000);
    check("async_data_b", {24'd0, data_b}, 8'hFF);
    check("async_ack", {31'd0, swap_ack}, 0);
    repeat (2) @(negedge clk);
    clear_n = 1'b1;
    count_change(n, acks);
    swap_req = 1'b0;
    check("restart_tick", n, 16);
    check("restart_row", {28'd0, comm}, 4'b1001);
    check("restart_no_ack", acks, 0);
    wait_comm(4'b1011);
    check("zeroed_row3_r", {24'd0, data_r}, 8'hFF);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
